// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the MEM-stage load/store unit:
//   - RV32 load/store funct3 encodings (F3_*)
//   - FSM state type lsu_state_t
//   - access-size decode helpers used by the lane logic
// ---------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } lsu_size_t;

    // Unlisted encodings (011, 110, 111) fall through to word.
    function automatic lsu_size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            F3_W:        return SZ_W;
            default:     return SZ_W;
        endcase
    endfunction

    function automatic logic f3_signed(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic.
//   Store side: byte-lane strobes and replicated write data.
//   Load side : byte/half extract from the read word plus sign/zero extend.
// Offsets are forced aligned by size: halfword looks only at off[1],
// word ignores the offset entirely.
// Ports:
//   i_st_off, i_st_funct3, i_st_data -> o_wstrb, o_wdata
//   i_ld_off, i_ld_funct3, i_ld_rdata -> o_ld_data
// ---------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_st_off,
    input  logic [2:0]  i_st_funct3,
    input  logic [31:0] i_st_data,
    input  logic [1:0]  i_ld_off,
    input  logic [2:0]  i_ld_funct3,
    input  logic [31:0] i_ld_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sgn;

    assign w_byte = i_ld_rdata[{i_ld_off, 3'b000} +: 8];
    assign w_half = i_ld_off[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
    assign w_sgn  = f3_signed(i_ld_funct3);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        o_wstrb = 4'b0000;
        o_wdata = '0;
        case (f3_size(i_st_funct3))
            SZ_B: begin
                o_wstrb = 4'b0001 << i_st_off;
                o_wdata = {4{i_st_data[7:0]}};
            end
            SZ_H: begin
                o_wstrb = i_st_off[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_st_data[15:0]}};
            end
            default: begin
                o_wstrb = 4'b1111;
                o_wdata = i_st_data;
            end
        endcase
    end

    always_comb begin
        o_ld_data = i_ld_rdata;
        case (f3_size(i_ld_funct3))
            SZ_B:    o_ld_data = {{24{w_sgn & w_byte[7]}}, w_byte};
            SZ_H:    o_ld_data = {{16{w_sgn & w_half[15]}}, w_half};
            default: o_ld_data = i_ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu
// MEM-stage load/store unit. Consumes the EX/MEM register, runs a
// req/gnt/rvalid handshake to data memory and holds stall_out high until
// the access completes. Non-memory instructions see no added latency.
//
// FSM: IDLE -> REQ -> (store) DONE / (load) WAIT -> DONE -> IDLE
//
// Ports:
//   clk, rst (sync, active-high)
//   MemRead_in, MemWrite_in, ALU_in, funct3_in, store_data_in  : from EX/MEM
//   stall_out                                                   : pipeline freeze
//   dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata / dm_gnt,
//   dm_rvalid, dm_rdata                                         : data memory
//   load_data_out                                               : to MEM/WB
//   misalign_out                                                : trap flag
//
// Build option: define MISALIGN_TRAP_EN to reject misaligned half/word
// accesses (IDLE->DONE with misalign_out=1). Without it, offsets are forced
// aligned and misalign_out is tied 0.
// ---------------------------------------------------------------------------
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic [31:0]       ALU_in,
    input  logic [2:0]        funct3_in,
    input  logic [XLEN-1:0]   store_data_in,
    output logic              stall_out,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_wstrb,
    output logic [XLEN-1:0]   dm_wdata,
    input  logic              dm_gnt,
    input  logic              dm_rvalid,
    input  logic [XLEN-1:0]   dm_rdata,
    output logic [XLEN-1:0]   load_data_out,
    output logic              misalign_out
);

    lsu_state_t  r_state;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;

    logic        w_op;
    logic        w_trap;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_load;

    assign w_op = MemRead_in | MemWrite_in;

`ifdef MISALIGN_TRAP_EN
    logic w_misaligned;
    always_comb begin
        w_misaligned = 1'b0;
        case (f3_size(funct3_in))
            SZ_H:    w_misaligned = ALU_in[0];
            SZ_W:    w_misaligned = (ALU_in[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
    end
    assign w_trap = w_misaligned;
`else
    assign w_trap = 1'b0;
    assign misalign_out = 1'b0;
`endif

    // Store lanes come from the live inputs (registered at issue); load
    // extraction uses the offset/funct3 captured at issue.
    lsu_align u_align (
        .i_st_off    (ALU_in[1:0]),
        .i_st_funct3 (funct3_in),
        .i_st_data   (store_data_in),
        .i_ld_off    (r_off),
        .i_ld_funct3 (r_funct3),
        .i_ld_rdata  (dm_rdata),
        .o_wstrb     (w_wstrb),
        .o_wdata     (w_wdata),
        .o_ld_data   (w_load)
    );

    // Combinational so the op presented in IDLE freezes EX/MEM in that same cycle.
    assign stall_out = ((r_state == IDLE) && w_op) || (r_state == REQ) || (r_state == WAIT);

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all of them update from pre-edge values.
        if (rst) begin
            r_state       <= IDLE;
            dm_req        <= 1'b0;
            dm_we         <= 1'b0;
            dm_addr       <= '0;
            dm_wstrb      <= 4'b0000;
            dm_wdata      <= '0;
            load_data_out <= '0;
            r_funct3      <= 3'b000;
            r_off         <= 2'b00;
`ifdef MISALIGN_TRAP_EN
            misalign_out  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_op) begin
                        if (w_trap) begin
                            r_state <= DONE;
`ifdef MISALIGN_TRAP_EN
                            misalign_out <= 1'b1;
`endif
                        end else begin
                            // Store wins when both request bits are set.
                            r_state  <= REQ;
                            dm_req   <= 1'b1;
                            dm_we    <= MemWrite_in;
                            dm_addr  <= {ALU_in[ADDR_W-1:2], 2'b00};
                            dm_wstrb <= MemWrite_in ? w_wstrb : 4'b0000;
                            dm_wdata <= MemWrite_in ? w_wdata : '0;
                            r_funct3 <= funct3_in;
                            r_off    <= ALU_in[1:0];
                        end
                    end
                end
                REQ: begin
                    if (dm_gnt) begin
                        dm_req  <= 1'b0;
                        r_state <= dm_we ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (dm_rvalid) begin
                        load_data_out <= w_load;
                        r_state       <= DONE;
                    end
                end
                DONE: begin
                    // The instruction advances at this edge; its request bits
                    // are still visible and must not re-issue.
                    r_state <= IDLE;
`ifdef MISALIGN_TRAP_EN
                    misalign_out <= 1'b0;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_lsu
// Directed bench for mem_stage_lsu. A small memory responder drives
// dm_gnt / dm_rvalid with programmable delays; expected values are
// hand-computed constants.
// ---------------------------------------------------------------------------
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead_in;
    logic        MemWrite_in;
    logic [31:0] ALU_in;
    logic [2:0]  funct3_in;
    logic [31:0] store_data_in;
    logic        stall_out;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic [31:0] load_data_out;
    logic        misalign_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Values captured by run_op during one transaction.
    int          cap_stalls;
    int          cap_req_cycles;
    bit          cap_stable;
    bit          cap_timeout;
    logic        cap_misalign;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [3:0]  cap_wstrb;
    logic [31:0] cap_wdata;

    mem_stage_lsu #(.ADDR_W(32), .XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .MemRead_in    (MemRead_in),
        .MemWrite_in   (MemWrite_in),
        .ALU_in        (ALU_in),
        .funct3_in     (funct3_in),
        .store_data_in (store_data_in),
        .stall_out     (stall_out),
        .dm_req        (dm_req),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_wstrb      (dm_wstrb),
        .dm_wdata      (dm_wdata),
        .dm_gnt        (dm_gnt),
        .dm_rvalid     (dm_rvalid),
        .dm_rdata      (dm_rdata),
        .load_data_out (load_data_out),
        .misalign_out  (misalign_out)
    );

    always #5 clk = ~clk;

    // Presents one op right after a rising edge and services it until
    // stall_out drops (DONE). gnt comes after gnt_dly REQ cycles, rvalid
    // after rv_dly WAIT cycles. Outputs are sampled on the falling edge.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata,
                          input int gnt_dly, input int rv_dly);
        int wait_cycles;
        bit granted;
        bit done;
        wait_cycles    = 0;
        granted        = 0;
        done           = 0;
        cap_stalls     = 0;
        cap_req_cycles = 0;
        cap_stable     = 1;
        cap_timeout    = 0;
        cap_misalign   = 1'b0;
        @(posedge clk);
        #1;
        MemRead_in    = ~st;
        MemWrite_in   = st;
        ALU_in        = addr;
        funct3_in     = f3;
        store_data_in = sdata;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            dm_gnt    = 1'b0;
            dm_rvalid = 1'b0;
            dm_rdata  = 32'h5A5A_5A5A;
            if (!stall_out) begin
                done         = 1;
                cap_misalign = misalign_out;
                MemRead_in   = 1'b0;
                MemWrite_in  = 1'b0;
            end else begin
                cap_stalls++;
                if (dm_req) begin
                    if (cap_req_cycles == 0) begin
                        cap_we    = dm_we;
                        cap_addr  = dm_addr;
                        cap_wstrb = dm_wstrb;
                        cap_wdata = dm_wdata;
                    end else if (dm_we !== cap_we || dm_addr !== cap_addr ||
                                 dm_wstrb !== cap_wstrb || dm_wdata !== cap_wdata) begin
                        cap_stable = 0;
                    end
                    if (cap_req_cycles == gnt_dly) begin
                        dm_gnt  = 1'b1;
                        granted = 1;
                    end
                    cap_req_cycles++;
                end else if (granted) begin
                    if (wait_cycles == rv_dly) begin
                        dm_rvalid = 1'b1;
                        dm_rdata  = rdata;
                    end
                    wait_cycles++;
                end
            end
        end
        if (!done) begin
            cap_timeout = 1;
            MemRead_in  = 1'b0;
            MemWrite_in = 1'b0;
            $display("FAIL run_op_timeout: stall_out still high after %0d cycles, required completion", cap_stalls);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; MemRead_in = 0; MemWrite_in = 0; ALU_in = 0; funct3_in = 0;
        store_data_in = 0; dm_gnt = 0; dm_rvalid = 0; dm_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", dm_req); end
        n_checks++; if (dm_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", dm_we); end
        n_checks++; if (dm_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", dm_addr); end
        n_checks++; if (dm_wstrb !== 4'h0) begin n_fail++; $display("FAIL reset_wstrb: got %h want 0", dm_wstrb); end
        n_checks++; if (dm_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", dm_wdata); end
        n_checks++; if (load_data_out !== 32'h0) begin n_fail++; $display("FAIL reset_load: got %h want 0", load_data_out); end
        n_checks++; if (misalign_out !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", misalign_out); end
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_out); end
        rst = 1'b0;
    endtask

    task automatic test_store_word();
        run_op(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 0);
        n_checks++; if (cap_stalls !== 2) begin n_fail++; $display("FAIL sw_stalls: got %0d want 2", cap_stalls); end
        n_checks++; if (cap_req_cycles !== 1) begin n_fail++; $display("FAIL sw_req_cycles: got %0d want 1", cap_req_cycles); end
        n_checks++; if (cap_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL sw_addr: got %h want 00000100", cap_addr); end
        n_checks++; if (cap_wstrb !== 4'b1111) begin n_fail++; $display("FAIL sw_wstrb: got %b want 1111", cap_wstrb); end
        n_checks++; if (cap_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_wdata: got %h want deadbeef", cap_wdata); end
        n_checks++; if (cap_we !== 1'b1) begin n_fail++; $display("FAIL sw_we: got %b want 1", cap_we); end
        n_checks++; if (load_data_out !== 32'h0) begin n_fail++; $display("FAIL sw_load_hold: got %h want 0", load_data_out); end
    endtask

    task automatic test_load_byte();
        run_op(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h8012_3456, 0, 0);
        n_checks++; if (cap_stalls !== 3) begin n_fail++; $display("FAIL lb_stalls: got %0d want 3", cap_stalls); end
        n_checks++; if (cap_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL lb_addr: got %h want 00000100", cap_addr); end
        n_checks++; if (cap_we !== 1'b0) begin n_fail++; $display("FAIL lb_we: got %b want 0", cap_we); end
        n_checks++; if (load_data_out !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data: got %h want ffffff80", load_data_out); end
        run_op(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h8012_3456, 0, 0);
        n_checks++; if (cap_stalls !== 3) begin n_fail++; $display("FAIL lbu_stalls: got %0d want 3", cap_stalls); end
        n_checks++; if (load_data_out !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_data: got %h want 00000080", load_data_out); end
    endtask

    task automatic test_store_sub();
        run_op(1'b1, 3'b001, 32'h0000_0102, 32'hABCD_1234, 32'h0, 0, 0);
        n_checks++; if (cap_stalls !== 2) begin n_fail++; $display("FAIL sh_stalls: got %0d want 2", cap_stalls); end
        n_checks++; if (cap_wstrb !== 4'b1100) begin n_fail++; $display("FAIL sh_wstrb: got %b want 1100", cap_wstrb); end
        n_checks++; if (cap_wdata !== 32'h1234_1234) begin n_fail++; $display("FAIL sh_wdata: got %h want 12341234", cap_wdata); end
        n_checks++; if (cap_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL sh_addr: got %h want 00000100", cap_addr); end
        run_op(1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 32'h0, 0, 0);
        n_checks++; if (cap_wstrb !== 4'b0010) begin n_fail++; $display("FAIL sb_wstrb: got %b want 0010", cap_wstrb); end
        n_checks++; if (cap_wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h want a5a5a5a5", cap_wdata); end
        n_checks++; if (load_data_out !== 32'h0000_0080) begin n_fail++; $display("FAIL sb_load_hold: got %h want 00000080", load_data_out); end
    endtask

    task automatic test_delayed();
        run_op(1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8765_4321, 4, 2);
        n_checks++; if (cap_stalls !== 9) begin n_fail++; $display("FAIL dly_stalls: got %0d want 9", cap_stalls); end
        n_checks++; if (cap_req_cycles !== 5) begin n_fail++; $display("FAIL dly_req_cycles: got %0d want 5", cap_req_cycles); end
        n_checks++; if (cap_stable !== 1'b1) begin n_fail++; $display("FAIL dly_stable: got %b want 1", cap_stable); end
        n_checks++; if (cap_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL dly_addr: got %h want 00000100", cap_addr); end
        n_checks++; if (load_data_out !== 32'hFFFF_8765) begin n_fail++; $display("FAIL dly_lh_data: got %h want ffff8765", load_data_out); end
    endtask

    task automatic test_back_to_back();
        run_op(1'b0, 3'b101, 32'h0000_0100, 32'h0, 32'h8765_F00D, 0, 0);
        n_checks++; if (load_data_out !== 32'h0000_F00D) begin n_fail++; $display("FAIL b2b_lhu_data: got %h want 0000f00d", load_data_out); end
        run_op(1'b0, 3'b111, 32'h0000_0104, 32'h0, 32'h8000_0001, 0, 0);
        n_checks++; if (cap_stalls !== 3) begin n_fail++; $display("FAIL b2b_f3_111_stalls: got %0d want 3", cap_stalls); end
        n_checks++; if (cap_addr !== 32'h0000_0104) begin n_fail++; $display("FAIL b2b_f3_111_addr: got %h want 00000104", cap_addr); end
        n_checks++; if (load_data_out !== 32'h8000_0001) begin n_fail++; $display("FAIL b2b_f3_111_data: got %h want 80000001", load_data_out); end
        @(negedge clk);
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_stall: got %b want 0", stall_out); end
        n_checks++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_req: got %b want 0", dm_req); end
    endtask

    task automatic test_misalign();
        run_op(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h1122_3344, 0, 0);
`ifdef MISALIGN_TRAP_EN
        n_checks++; if (cap_stalls !== 1) begin n_fail++; $display("FAIL mis_stalls: got %0d want 1", cap_stalls); end
        n_checks++; if (cap_req_cycles !== 0) begin n_fail++; $display("FAIL mis_req: got %0d want 0", cap_req_cycles); end
        n_checks++; if (cap_misalign !== 1'b1) begin n_fail++; $display("FAIL mis_flag: got %b want 1", cap_misalign); end
        n_checks++; if (load_data_out !== 32'h8000_0001) begin n_fail++; $display("FAIL mis_load_hold: got %h want 80000001", load_data_out); end
        @(negedge clk);
        n_checks++; if (misalign_out !== 1'b0) begin n_fail++; $display("FAIL mis_flag_len: got %b want 0", misalign_out); end
`else
        n_checks++; if (cap_stalls !== 3) begin n_fail++; $display("FAIL mis_stalls: got %0d want 3", cap_stalls); end
        n_checks++; if (cap_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL mis_addr: got %h want 00000100", cap_addr); end
        n_checks++; if (cap_misalign !== 1'b0) begin n_fail++; $display("FAIL mis_flag: got %b want 0", cap_misalign); end
        n_checks++; if (load_data_out !== 32'h1122_3344) begin n_fail++; $display("FAIL mis_lw_data: got %h want 11223344", load_data_out); end
`endif
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #1;
        MemRead_in = 1'b1; MemWrite_in = 1'b0; ALU_in = 32'h0000_0200; funct3_in = 3'b010;
        @(negedge clk);                       // IDLE
        @(negedge clk);                       // REQ
        n_checks++; if (dm_req !== 1'b1) begin n_fail++; $display("FAIL rmid_req: got %b want 1", dm_req); end
        dm_gnt = 1'b1;
        @(negedge clk);                       // WAIT
        dm_gnt = 1'b0;
        n_checks++; if (stall_out !== 1'b1 || dm_req !== 1'b0) begin n_fail++; $display("FAIL rmid_wait: got stall=%b req=%b want stall=1 req=0", stall_out, dm_req); end
        rst = 1'b1; MemRead_in = 1'b0;
        @(negedge clk);
        n_checks++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req_drop: got %b want 0", dm_req); end
        n_checks++; if (load_data_out !== 32'h0) begin n_fail++; $display("FAIL rmid_load_clr: got %h want 0", load_data_out); end
        rst = 1'b0; dm_rvalid = 1'b1; dm_gnt = 1'b1; dm_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dm_rvalid = 1'b0; dm_gnt = 1'b0;
        n_checks++; if (load_data_out !== 32'h0) begin n_fail++; $display("FAIL rmid_stale_rvalid: got %h want 0", load_data_out); end
        n_checks++; if (stall_out !== 1'b0 || dm_req !== 1'b0) begin n_fail++; $display("FAIL rmid_idle: got stall=%b req=%b want 0 0", stall_out, dm_req); end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_store_sub();
        test_delayed();
        test_back_to_back();
        test_misalign();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
